// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared function codes, controller state enum and decode helpers
package lsu_pkg;

  localparam logic [3:0] FUNC_LB  = 4'b0000;
  localparam logic [3:0] FUNC_LH  = 4'b0001;
  localparam logic [3:0] FUNC_LW  = 4'b0010;
  localparam logic [3:0] FUNC_LBU = 4'b0100;
  localparam logic [3:0] FUNC_LHU = 4'b0101;
  localparam logic [3:0] FUNC_SB  = 4'b1000;
  localparam logic [3:0] FUNC_SH  = 4'b1001;
  localparam logic [3:0] FUNC_SW  = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } ctrl_state_e;

  function automatic logic func_legal(input logic [3:0] func);
    case (func)
      FUNC_LB, FUNC_LH, FUNC_LW, FUNC_LBU, FUNC_LHU,
      FUNC_SB, FUNC_SH, FUNC_SW: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic func_is_store(input logic [3:0] func);
    return func[3];
  endfunction

endpackage

// File: rtl/lsu.sv
// rtl/lsu.sv - combinational address generation, load formatting and store merge
module lsu
  import lsu_pkg::*;
(
  input  logic [3:0]  func,
  input  logic [31:0] base,
  input  logic [11:0] offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rwin,
  output logic [29:0] word_addr,
  output logic [31:0] rdata,
  output logic [63:0] wwin,
  output logic        err
);

  logic [31:0] addr;
  logic [5:0]  shamt;
  logic [31:0] rsel;
  logic [63:0] mask;

  assign addr      = base + {{20{offset[11]}}, offset};
  assign word_addr = addr[31:2];
  assign shamt     = {addr[1:0], 3'b000};
  assign rsel      = 32'(rwin >> shamt);
  assign err       = !func_legal(func);

  always_comb begin
    rdata = '0;
    case (func)
      FUNC_LB:  rdata = {{24{rsel[7]}}, rsel[7:0]};
      FUNC_LH:  rdata = {{16{rsel[15]}}, rsel[15:0]};
      FUNC_LW:  rdata = rsel;
      FUNC_LBU: rdata = {24'b0, rsel[7:0]};
      FUNC_LHU: rdata = {16'b0, rsel[15:0]};
      default:  rdata = '0;
    endcase
  end

  // Byte lanes replaced within the two-word window; unaligned halves/words may spill into the upper word.
  always_comb begin
    mask = '0;
    case (func[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  assign wwin = (rwin & ~(mask << shamt)) | (({32'b0, wdata} & mask) << shamt);

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - request sequencer: read, optional read-modify-write, then response
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_func,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  ctrl_state_e state, state_next;

  logic [3:0]  func_q;
  logic [31:0] base_q;
  logic [11:0] offset_q;
  logic [31:0] wdata_q;
  logic [63:0] win_q;

  logic [29:0] lsu_word_addr;
  logic [31:0] lsu_rdata;
  logic [63:0] lsu_wwin;
  logic        lsu_err;

  lsu u_lsu (
    .func      (func_q),
    .base      (base_q),
    .offset    (offset_q),
    .wdata     (wdata_q),
    .rwin      (win_q),
    .word_addr (lsu_word_addr),
    .rdata     (lsu_rdata),
    .wwin      (lsu_wwin),
    .err       (lsu_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q   <= '0;
      base_q   <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      win_q    <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        func_q   <= req_func;
        base_q   <= req_base;
        offset_q <= req_offset;
        wdata_q  <= req_wdata;
      end
      if (state == ST_RWAIT && mem_rvalid) win_q <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req_valid) state_next = func_legal(req_func) ? ST_RD : ST_RESP;
      ST_RD:    if (mem_gnt) state_next = ST_RWAIT;
      ST_RWAIT: if (mem_rvalid) state_next = func_is_store(func_q) ? ST_WR : ST_RESP;
      ST_WR:    if (mem_gnt) state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Memory outputs derive only from state and registered fields, so they hold while gnt is low.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = lsu_word_addr;
      end
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lsu_word_addr;
        mem_wdata = lsu_wwin;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = lsu_err;
        resp_rdata = lsu_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and randomized checks of lsu_ctrl against a byte-level memory model
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  mem8 [logic [31:0]];
  logic [63:0] last_wdata;
  logic [29:0] last_waddr;
  logic [31:0] got_rdata;
  logic        got_err;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem8.exists(a)) mem8[a] = 8'($urandom);
    return mem8[a];
  endfunction

  function automatic void set_word(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) mem8[a + 32'(k)] = d[8*k +: 8];
  endfunction

  function automatic logic [63:0] window(input logic [31:0] a);
    logic [63:0] w;
    logic [31:0] wb;
    wb = {a[31:2], 2'b00};
    for (int k = 0; k < 8; k++) w[8*k +: 8] = rd_byte(wb + 32'(k));
    return w;
  endfunction

  function automatic logic is_legal(input logic [3:0] f);
    return f inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
  endfunction

  // One complete transaction; memory handshakes delayed by the given wait counts.
  task automatic run_op(input logic [3:0] f, input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] wd, input int gw_rd, input int rv_w,
                        input int gw_wr, input int rr_w);
    logic [31:0] a, exp_rd;
    logic [63:0] win_pre, win_post;
    int sz;
    a  = base + {{20{off[11]}}, off};
    sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    exp_rd = '0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_func = f; req_base = base; req_offset = off; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_func = 4'($urandom); req_base = $urandom;
    req_offset = 12'($urandom); req_wdata = $urandom;
    if (is_legal(f)) begin
      win_pre = window(a);
      if (!f[3]) begin
        for (int k = 0; k < sz; k++) exp_rd[8*k +: 8] = rd_byte(a + 32'(k));
        if (!f[2] && sz == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
        if (!f[2] && sz == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
      end
      for (int i = 0; i <= gw_rd; i++) begin
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, a[31:2]);
        chk("rd_busy", {req_ready, resp_valid}, 0);
        mem_gnt    = (i == gw_rd);
        mem_rvalid = (i == gw_rd) ? 1'b0 : 1'($urandom);
        mem_rdata  = {$urandom, $urandom};
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      for (int i = 0; i <= rv_w; i++) begin
        chk("rwait_idle_mem", {mem_req, mem_we, resp_valid, req_ready}, 0);
        mem_rvalid = (i == rv_w);
        mem_rdata  = (i == rv_w) ? win_pre : {$urandom, $urandom};
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      if (f[3]) begin
        for (int k = 0; k < sz; k++) mem8[a + 32'(k)] = wd[8*k +: 8];
        win_post = window(a);
        for (int i = 0; i <= gw_wr; i++) begin
          chk("wr_req", {mem_req, mem_we}, 2'b11);
          chk("wr_addr", mem_addr, a[31:2]);
          chk("wr_data", mem_wdata, win_post);
          chk("wr_busy", {req_ready, resp_valid}, 0);
          last_wdata = mem_wdata;
          last_waddr = mem_addr;
          mem_gnt    = (i == gw_wr);
          mem_rvalid = 1'($urandom);
          mem_rdata  = {$urandom, $urandom};
          @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
    end
    for (int i = 0; i <= rr_w; i++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_err", resp_err, !is_legal(f));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_quiet_mem", {mem_req, mem_we, req_ready}, 0);
      if (i == 0) begin got_rdata = resp_rdata; got_err = resp_err; end
      resp_ready = (i == rr_w);
      mem_rvalid = 1'($urandom);
      @(negedge clk);
    end
    resp_ready = 1'b0; mem_rvalid = 1'b0;
    chk("done_resp_low", resp_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  initial begin
    logic [3:0] legal_set [8];
    logic [3:0] f;
    legal_set = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    rst_n = 1'b0; req_valid = 1'b0; req_func = '0; req_base = '0; req_offset = '0;
    req_wdata = '0; resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    last_wdata = '0; last_waddr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);

    // lw, zero-wait
    set_word(32'h1004, 32'hDEAD_BEEF); set_word(32'h1008, 32'h0);
    run_op(4'h2, 32'h0000_1000, 12'h004, 32'h0, 0, 0, 0, 0);
    chk("t1_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("t1_err", got_err, 0);

    // lb / lbu crossing down with a negative offset
    set_word(32'h0FFC, 32'h8000_0000); set_word(32'h1000, 32'h0);
    run_op(4'h0, 32'h0000_1003, 12'hFFC, 32'h0, 0, 0, 0, 0);
    chk("t2_lb", got_rdata, 32'hFFFF_FF80);
    run_op(4'h4, 32'h0000_1003, 12'hFFC, 32'h0, 0, 0, 0, 0);
    chk("t2_lbu", got_rdata, 32'h0000_0080);

    // sh spanning two words
    set_word(32'h2000, 32'hFFFF_FFFF); set_word(32'h2004, 32'hFFFF_FFFF);
    run_op(4'h9, 32'h0000_2003, 12'h000, 32'h0000_1234, 0, 0, 0, 0);
    chk("t3_waddr", last_waddr, 30'h800);
    chk("t3_wdata", last_wdata, 64'hFFFF_FF12_34FF_FFFF);

    // sw with grant and response back-pressure
    run_op(4'hA, 32'h0000_2100, 12'h008, 32'hCAFE_F00D, 5, 1, 5, 3);

    // illegal func
    run_op(4'h3, 32'h0000_1000, 12'h004, 32'h0, 0, 0, 0, 0);
    chk("t5_err", got_err, 1);
    chk("t5_rdata", got_rdata, 0);

    // reset while in WR
    req_valid = 1'b1; req_func = 4'hA; req_base = 32'h0000_3000; req_offset = '0;
    req_wdata = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("t6_in_wr", {mem_req, mem_we}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_after_rst", {mem_req, mem_we, resp_valid, req_ready}, 4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_write", {mem_req, mem_we}, 0);
    end

    // randomized traffic over a small, overlapping region
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        f = 4'($urandom);
        while (is_legal(f)) f = 4'($urandom);
      end else begin
        f = legal_set[$urandom_range(0, 7)];
      end
      run_op(f, 32'h0000_0100 + 32'($urandom_range(0, 31)),
             12'($urandom_range(0, 32)) - 12'd16, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
